// File: rtl/step_watchdog.sv
// Per-channel step-activity watchdog: idle counters with programmable timeouts, arming, sticky alerts and shutdown request.
// Optional registered debug readout of a channel's idle counter is enabled with `define STEP_WATCHDOG_DBG_EN.
module step_watchdog #(
  parameter int          NCH             = 6,
  parameter int          CNT_BITS        = 32,
  parameter int unsigned TIMEOUT_DEFAULT = 480000000,
  parameter int          CH_BITS         = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      step,
  input  logic [NCH-1:0]      arm,
  input  logic                disarm,
  input  logic                to_wr_en,
  input  logic [CH_BITS-1:0]  to_wr_ch,
  input  logic [CNT_BITS-1:0] to_wr_data,
  input  logic [NCH-1:0]      shut_mask,
  input  logic                clr_alert,
  input  logic [CH_BITS-1:0]  dbg_sel,
  output logic [NCH-1:0]      expired,
  output logic [NCH-1:0]      armed,
  output logic [NCH-1:0]      alert,
  output logic                req_shutdown,
  output logic [7:0]          dbg_idle
);

  typedef enum logic {
    ST_DISARMED = 1'b0,
    ST_ARMED    = 1'b1
  } arm_state_t;

  arm_state_t          state_q   [NCH];
  arm_state_t          state_d   [NCH];
  logic [CNT_BITS-1:0] cnt_q     [NCH];
  logic [CNT_BITS-1:0] timeout_q [NCH];
  logic [NCH-1:0]      prev_q;
  logic [NCH-1:0]      trans;
  logic [NCH-1:0]      wr_hit;
  logic [NCH-1:0]      hit;
  logic [NCH-1:0]      alert_q;
  logic                req_q;

  assign trans = step ^ prev_q;

  always_comb begin
    wr_hit  = '0;
    expired = '0;
    armed   = '0;
    for (int i = 0; i < NCH; i++) begin
      // Channel indices >= NCH never match, so such writes are dropped.
      wr_hit[i]  = to_wr_en && (to_wr_ch == CH_BITS'(i));
      expired[i] = (cnt_q[i] == timeout_q[i]) && (timeout_q[i] != '0);
      armed[i]   = (state_q[i] == ST_ARMED);
    end
  end

  assign hit = expired & armed;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_DISARMED: if (arm[i] && !disarm) state_d[i] = ST_ARMED;
        ST_ARMED:    if (disarm) state_d[i] = ST_DISARMED;
        default:     state_d[i] = ST_DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // prev tracks step even during reset so the first cycle after reset sees no edge.
    prev_q <= step;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]     <= '0;
        timeout_q[i] <= CNT_BITS'(TIMEOUT_DEFAULT);
        state_q[i]   <= ST_DISARMED;
      end
      alert_q <= '0;
      req_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_hit[i]) timeout_q[i] <= to_wr_data;
        if (wr_hit[i] || trans[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] != timeout_q[i]) cnt_q[i] <= cnt_q[i] + CNT_BITS'(1);
        state_q[i] <= state_d[i];
        if (hit[i]) alert_q[i] <= 1'b1;
        else if (clr_alert) alert_q[i] <= 1'b0;
      end
      req_q <= req_q | (|(hit & shut_mask));
    end
  end

  assign alert        = alert_q;
  assign req_shutdown = req_q;

`ifdef STEP_WATCHDOG_DBG_EN
  logic [CNT_BITS-1:0] dbg_cnt;
  logic [7:0]          dbg_q;

  always_comb begin
    dbg_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (dbg_sel == CH_BITS'(i)) dbg_cnt = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dbg_q <= '0;
    else     dbg_q <= dbg_cnt[CNT_BITS-1 -: 8];
  end

  assign dbg_idle = dbg_q;
`else
  logic unused_dbg_sel;
  assign unused_dbg_sel = ^dbg_sel;
  assign dbg_idle       = '0;
`endif

endmodule

// File: tb/tb_step_watchdog.sv
// Bench for step_watchdog: timestamp-based reference model compared every cycle, plus directed literal checks.
module tb_step_watchdog;
  localparam int NCH      = 6;
  localparam int CNT_BITS = 12;
  localparam int CH_BITS  = 3;
  localparam int TDEF     = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      step;
  logic [NCH-1:0]      arm;
  logic                disarm;
  logic                to_wr_en;
  logic [CH_BITS-1:0]  to_wr_ch;
  logic [CNT_BITS-1:0] to_wr_data;
  logic [NCH-1:0]      shut_mask;
  logic                clr_alert;
  logic [CH_BITS-1:0]  dbg_sel;
  logic [NCH-1:0]      expired;
  logic [NCH-1:0]      armed;
  logic [NCH-1:0]      alert;
  logic                req_shutdown;
  logic [7:0]          dbg_idle;

  always #5 clk = ~clk;

  step_watchdog #(
    .NCH(NCH), .CNT_BITS(CNT_BITS), .TIMEOUT_DEFAULT(TDEF), .CH_BITS(CH_BITS)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .arm(arm), .disarm(disarm),
    .to_wr_en(to_wr_en), .to_wr_ch(to_wr_ch), .to_wr_data(to_wr_data),
    .shut_mask(shut_mask), .clr_alert(clr_alert), .dbg_sel(dbg_sel),
    .expired(expired), .armed(armed), .alert(alert),
    .req_shutdown(req_shutdown), .dbg_idle(dbg_idle)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model: each channel remembers the cycle of its last activity; idle time is just a difference.
  longint         cyc = 0;
  longint         last_ev [NCH];
  int             m_to [NCH];
  logic [NCH-1:0] m_prev  = '0;
  logic [NCH-1:0] m_armed = '0;
  logic [NCH-1:0] m_alert = '0;
  logic           m_req   = 1'b0;
  logic [7:0]     m_dbg   = '0;

  function automatic longint m_cnt(int i);
    longint idle = cyc - last_ev[i];
    return (idle < longint'(m_to[i])) ? idle : longint'(m_to[i]);
  endfunction

  function automatic logic [NCH-1:0] m_expired();
    logic [NCH-1:0] e;
    for (int i = 0; i < NCH; i++)
      e[i] = (m_to[i] != 0) && ((cyc - last_ev[i]) >= longint'(m_to[i]));
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
  endtask

  // Advances the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [NCH-1:0] e;
    logic [NCH-1:0] h;
    logic [7:0]     nd;
    e  = m_expired();
    h  = e & m_armed;
    nd = '0;
`ifdef STEP_WATCHDOG_DBG_EN
    if (int'(dbg_sel) < NCH) nd = 8'((m_cnt(int'(dbg_sel)) >> (CNT_BITS - 8)) & 255);
`endif
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        last_ev[i] = cyc + 1;
        m_to[i]    = TDEF;
      end
      m_armed = '0;
      m_alert = '0;
      m_req   = 1'b0;
      m_dbg   = '0;
    end else begin
      m_dbg = nd;
      if ((h & shut_mask) != '0) m_req = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (h[i]) m_alert[i] = 1'b1;
        else if (clr_alert) m_alert[i] = 1'b0;
        if (disarm) m_armed[i] = 1'b0;
        else if (arm[i]) m_armed[i] = 1'b1;
        if (to_wr_en && int'(to_wr_ch) == i) begin
          m_to[i]    = int'(to_wr_data);
          last_ev[i] = cyc + 1;
        end else if (step[i] != m_prev[i]) begin
          last_ev[i] = cyc + 1;
        end
      end
    end
    m_prev = step;
    cyc++;
  endtask

  task automatic compare_model();
    check("model_expired", 32'(expired), 32'(m_expired()));
    check("model_armed", 32'(armed), 32'(m_armed));
    check("model_alert", 32'(alert), 32'(m_alert));
    check("model_req_shutdown", 32'(req_shutdown), 32'(m_req));
    check("model_dbg_idle", 32'(dbg_idle), 32'(m_dbg));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    step = '0; arm = '0; disarm = 1'b0; to_wr_en = 1'b0; to_wr_ch = '0;
    to_wr_data = '0; shut_mask = '0; clr_alert = 1'b0; dbg_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      last_ev[i] = 0;
      m_to[i]    = TDEF;
    end
    do_reset();
    check("reset_expired", 32'(expired), 32'h0);
    check("reset_armed", 32'(armed), 32'h0);
    check("reset_alert", 32'(alert), 32'h0);
    check("reset_req", 32'(req_shutdown), 32'h0);
    check("reset_dbg", 32'(dbg_idle), 32'h0);

    // Step 0 toggles on the first cycle after reset; the others stay idle.
    step[0] = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    check("exp_before_timeout", 32'(expired), 32'h0);
    tick();
    check("exp_idle_channels", 32'(expired), 32'h3e);
    tick();
    check("exp_ch0_late", 32'(expired), 32'h3f);

    // Armed, masked-in expiry on channel 5.
    arm = 6'b100000; shut_mask = 6'b100000;
    tick();
    check("arm5_armed", 32'(armed), 32'h20);
    check("arm5_alert_lag", 32'(alert), 32'h0);
    tick();
    check("arm5_alert", 32'(alert), 32'h20);
    tick();
    check("arm5_req", 32'(req_shutdown), 32'h1);
    arm = '0; disarm = 1'b1; clr_alert = 1'b1;
    tick();
    check("disarm_armed", 32'(armed), 32'h0);
    check("alert_set_wins", 32'(alert[5]), 32'h1);
    check("req_sticky", 32'(req_shutdown), 32'h1);
    disarm = 1'b0; clr_alert = 1'b0;

    // Timeout writes restart the counter; zero disables the channel.
    to_wr_en = 1'b1; to_wr_ch = 3'd2; to_wr_data = 12'd3;
    tick();
    to_wr_en = 1'b0;
    check("wr_ch2_restart", 32'(expired[2]), 32'h0);
    tick(); tick();
    check("wr_ch2_early", 32'(expired[2]), 32'h0);
    tick();
    check("wr_ch2_expired", 32'(expired[2]), 32'h1);
    to_wr_en = 1'b1; to_wr_ch = 3'd3; to_wr_data = 12'd0;
    tick();
    to_wr_en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("ch3_disabled", 32'(expired[3]), 32'h0);
    end

    // Simultaneous arm and disarm: disarm wins. Then keep channel 1 busy.
    arm = 6'b000010; disarm = 1'b1;
    tick();
    check("arm_disarm_race", 32'(armed[1]), 32'h0);
    arm = '0; disarm = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k % 5 == 0) step[1] = ~step[1];
      tick();
      check("ch1_active", 32'(expired[1]), 32'h0);
    end

    // Armed expiry on channel 4 without shutdown permission.
    do_reset();
    arm = 6'b010000; shut_mask = '0;
    for (int k = 0; k < 12; k++) tick();
    check("ch4_alert", 32'(alert), 32'h10);
    check("ch4_no_req", 32'(req_shutdown), 32'h0);
    step[4] = ~step[4];
    tick();
    clr_alert = 1'b1;
    tick();
    clr_alert = 1'b0;
    check("ch4_alert_cleared", 32'(alert[4]), 32'h0);
    arm = '0;

    // Debug readout of channel 0 with a long timeout.
    to_wr_en = 1'b1; to_wr_ch = 3'd0; to_wr_data = 12'd4095; dbg_sel = 3'd0;
    tick();
    to_wr_en = 1'b0;
    for (int k = 0; k < 33; k++) tick();
`ifdef STEP_WATCHDOG_DBG_EN
    check("dbg_idle_value", 32'(dbg_idle), 32'h2);
`else
    check("dbg_idle_value", 32'(dbg_idle), 32'h0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 11) == 0) step[i] = ~step[i];
      arm        = NCH'($urandom_range(0, 3) == 0 ? $urandom : 0);
      disarm     = ($urandom_range(0, 19) == 0);
      clr_alert  = ($urandom_range(0, 9) == 0);
      shut_mask  = NCH'($urandom);
      dbg_sel    = CH_BITS'($urandom_range(0, 7));
      to_wr_en   = ($urandom_range(0, 15) == 0);
      to_wr_ch   = CH_BITS'($urandom_range(0, 7));
      to_wr_data = ($urandom_range(0, 19) == 0) ? CNT_BITS'($urandom)
                                                 : CNT_BITS'($urandom_range(0, 14));
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
